mac_window_ctrl: RTL and testbench
==================================

Name: mac_window_ctrl

Overview:
Sequences the shared MAC datapath over fixed windows of audio samples. Each window runs: clear accumulator, accept window_p sample handshakes, drain the MAC pipeline, capture the accumulated result.
Sits between the SIPO sample stream and the mac instance. Replaces the ad-hoc counter/compare reset and capture logic at top level.
Feeds captured result and magnitude to the SSD display path.

Parameters:
width_p, 32, MAC result width (signed two's complement)
window_p, 44100, samples accumulated per window (>=1)
drain_p, 2, cycles waited after last accepted sample before capture (>=1; covers MAC latency)
cnt_width_p, 8, width of completed-window counter

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous active-low reset
enable_i  in  1  run windows continuously while high
sample_valid_i  in  1  upstream sample valid (from SIPO)
sample_ready_o  out  1  upstream ready; handshake = sample_valid_i & sample_ready_o
mac_valid_o  out  1  valid into MAC
mac_ready_i  in  1  MAC ready
mac_clear_o  out  1  one-cycle accumulator clear to MAC (drives MAC reset_i)
mac_data_i  in  width_p  MAC accumulator output, signed
result_o  out  width_p  last captured accumulator value, signed
result_mag_o  out  width_p  |result_o|, saturated to 2^(width_p-1)-1 for most-negative input
result_v_o  out  1  one-cycle pulse when result_o/result_mag_o update
window_count_o  out  cnt_width_p  number of completed windows, wraps
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (reset_n_i==0 at posedge):
  - state=IDLE.
  - result_o=0, result_mag_o=0, result_v_o=0, window_count_o=0.
  - Sample and drain counters=0.
  - Reset wins over all other inputs; reset mid-window discards partial accumulation and produces no result_v_o.
- States: IDLE, CLEAR, ACCUM, DRAIN, CAPTURE.
- IDLE:
  - sample_ready_o=0, mac_valid_o=0, mac_clear_o=0.
  - enable_i==1 -> CLEAR next cycle.
- CLEAR (exactly 1 cycle):
  - mac_clear_o=1, sample_ready_o=0.
  - Sample counter <= 0. Always -> ACCUM.
- ACCUM:
  - mac_valid_o=sample_valid_i; sample_ready_o=mac_ready_i (combinational pass-through, no buffering).
  - Each handshake increments the sample counter.
  - Handshake while counter==window_p-1 -> DRAIN; drain counter <= 0.
  - enable_i deassertion is ignored mid-window; the window always completes.
- DRAIN:
  - sample_ready_o=0, mac_valid_o=0.
  - Drain counter increments each cycle; counter==drain_p-1 -> CAPTURE.
- CAPTURE (1 cycle):
  - result_o <= mac_data_i; result_mag_o <= abs(mac_data_i) with saturation.
  - result_v_o=1 on the following cycle (registered pulse, aligned with new result_o).
  - window_count_o += 1, wrapping 2^cnt_width_p-1 -> 0.
  - Next state: enable_i ? CLEAR : IDLE.
- Throughput:
  - window_p + drain_p + 2 cycles minimum per window (CLEAR + ACCUM + DRAIN + CAPTURE).
  - No sample is accepted in CLEAR/DRAIN/CAPTURE/IDLE; upstream SIPO is back-pressured.
- window_p==1: first ACCUM handshake goes directly to DRAIN.
- Counter widths: sample counter $clog2(window_p+1) bits; drain counter $clog2(drain_p+1) bits.
- mac_clear_o is driven only from the state register, so it is glitch-free.
- result_o holds between captures.

Decomposition:
- Shared package mac_ctrl_pkg holds the state enum typedef (IDLE, CLEAR, ACCUM, DRAIN, CAPTURE) and the default window/drain constants.
- One natural sub-module, sat_abs: width-parameterised combinational saturating absolute value for result_mag_o. Reusable by the SSD path.
- Counters stay inline.

Test Plan:
(All with window_p=4, drain_p=2, width_p=32, cnt_width_p=8.)
- Reset release, enable_i=1:
  - mac_clear_o high exactly 1 cycle, 1 cycle after reset release.
  - sample_ready_o low during CLEAR, then tracks mac_ready_i.
- 4 handshakes with mac_data_i=0x00000123 after drain:
  - result_v_o pulses once; result_o=0x123, result_mag_o=0x123, window_count_o=1.
  - sample_ready_o=0 for exactly 4 cycles (DRAIN+CAPTURE+CLEAR) before the next window.
- mac_data_i=0xFFFFFF00 at capture -> result_o=0xFFFFFF00, result_mag_o=0x00000100.
- mac_data_i=0x80000000 at capture -> result_mag_o=0x7FFFFFFF.
- mac_ready_i=0 for 3 cycles mid-window with sample_valid_i=1:
  - no counter advance and sample_ready_o=0 during the stall.
  - Window still closes after exactly 4 handshakes.
- enable_i dropped after 2nd handshake:
  - window completes, result_v_o pulses, then IDLE with busy_o=0.
- reset_n_i=0 after 3rd handshake:
  - no result_v_o; result_o=0, window_count_o=0.
- Wrap: 256 windows -> window_count_o returns to 0.

Source files
------------

// File: rtl/mac_ctrl_pkg.sv
// Shared definitions for the MAC window sequencer: FSM state encoding and
// default window/drain sizing.
package mac_ctrl_pkg;

    localparam int unsigned WINDOW_DEFAULT = 44100;
    localparam int unsigned DRAIN_DEFAULT  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/sat_abs.sv
// Combinational absolute value of a signed two's-complement word. The most
// negative input saturates to the largest positive value instead of wrapping.
module sat_abs #(
    parameter int unsigned width_p = 32
) (
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] mag_o
);

    localparam logic [width_p-1:0] MOST_NEG = {1'b1, {(width_p-1){1'b0}}};

    always_comb begin
        if (data_i == MOST_NEG) begin
            mag_o = ~MOST_NEG;
        end else if (data_i[width_p-1]) begin
            mag_o = -data_i;
        end else begin
            mag_o = data_i;
        end
    end

endmodule

// File: rtl/mac_window_ctrl.sv
// Sequences the shared MAC over fixed sample windows: clear, accumulate
// window_p handshakes, wait out the MAC latency, then capture the result.
module mac_window_ctrl
    import mac_ctrl_pkg::*;
#(
    parameter int unsigned width_p     = 32,
    parameter int unsigned window_p    = WINDOW_DEFAULT,
    parameter int unsigned drain_p     = DRAIN_DEFAULT,
    parameter int unsigned cnt_width_p = 8
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          enable_i,
    input  logic                          sample_valid_i,
    output logic                          sample_ready_o,
    output logic                          mac_valid_o,
    input  logic                          mac_ready_i,
    output logic                          mac_clear_o,
    input  logic signed [width_p-1:0]     mac_data_i,
    output logic signed [width_p-1:0]     result_o,
    output logic        [width_p-1:0]     result_mag_o,
    output logic                          result_v_o,
    output logic        [cnt_width_p-1:0] window_count_o,
    output logic                          busy_o
);

    localparam int unsigned SAMP_W  = $clog2(window_p + 1);
    localparam int unsigned DRAIN_W = $clog2(drain_p + 1);
    localparam logic [SAMP_W-1:0]  SAMP_LAST  = SAMP_W'(window_p - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(drain_p - 1);

    state_e                     state_q, state_d;
    logic [SAMP_W-1:0]          samp_cnt_q, samp_cnt_d;
    logic [DRAIN_W-1:0]         drain_cnt_q, drain_cnt_d;
    logic signed [width_p-1:0]  result_q, result_d;
    logic [width_p-1:0]         mag_q, mag_d;
    logic                       result_v_q, result_v_d;
    logic [cnt_width_p-1:0]     win_cnt_q, win_cnt_d;
    logic                       clear_q, clear_d;
    logic                       busy_q, busy_d;
    logic                       accum_q, accum_d;
    logic [width_p-1:0]         mag_w;
    logic                       handshake;

    sat_abs #(.width_p(width_p)) u_sat_abs (
        .data_i (mac_data_i),
        .mag_o  (mag_w)
    );

    // Ready/valid are pure pass-throughs in ACCUM so the SIPO sees MAC stalls directly.
    assign sample_ready_o = accum_q & mac_ready_i;
    assign mac_valid_o    = accum_q & sample_valid_i;
    assign handshake      = sample_valid_i & sample_ready_o;

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_d     = state_q;
        samp_cnt_d  = samp_cnt_q;
        drain_cnt_d = drain_cnt_q;
        result_d    = result_q;
        mag_d       = mag_q;
        result_v_d  = 1'b0;
        win_cnt_d   = win_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                samp_cnt_d = '0;
                state_d    = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (handshake) begin
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                    if (samp_cnt_q == SAMP_LAST) begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
                if (drain_cnt_q == DRAIN_LAST) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                result_d   = mac_data_i;
                mag_d      = mag_w;
                result_v_d = 1'b1;
                win_cnt_d  = win_cnt_q + cnt_width_p'(1);
                state_d    = enable_i ? ST_CLEAR : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Decoded from the next state and registered, so these never glitch.
        clear_d = (state_d == ST_CLEAR);
        busy_d  = (state_d != ST_IDLE);
        accum_d = (state_d == ST_ACCUM);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            samp_cnt_q  <= '0;
            drain_cnt_q <= '0;
            result_q    <= '0;
            mag_q       <= '0;
            result_v_q  <= 1'b0;
            win_cnt_q   <= '0;
            clear_q     <= 1'b0;
            busy_q      <= 1'b0;
            accum_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            result_q    <= result_d;
            mag_q       <= mag_d;
            result_v_q  <= result_v_d;
            win_cnt_q   <= win_cnt_d;
            clear_q     <= clear_d;
            busy_q      <= busy_d;
            accum_q     <= accum_d;
        end
    end

    assign mac_clear_o    = clear_q;
    assign busy_o         = busy_q;
    assign result_o       = result_q;
    assign result_mag_o   = mag_q;
    assign result_v_o     = result_v_q;
    assign window_count_o = win_cnt_q;

endmodule

// File: tb/tb_mac_window_ctrl.sv
// Scoreboard bench for mac_window_ctrl with window_p=4, drain_p=2: expected
// captures are queued by the stimulus and checked by a result_v_o monitor.
module tb_mac_window_ctrl;

    logic               clk_i = 1'b0;
    logic               reset_n_i;
    logic               enable_i;
    logic               sample_valid_i;
    logic               sample_ready_o;
    logic               mac_valid_o;
    logic               mac_ready_i;
    logic               mac_clear_o;
    logic signed [31:0] mac_data_i;
    logic signed [31:0] result_o;
    logic [31:0]        result_mag_o;
    logic               result_v_o;
    logic [7:0]         window_count_o;
    logic               busy_o;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] mag;
        logic [7:0]  cnt;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_cnt = 8'd0;

    mac_window_ctrl #(
        .width_p     (32),
        .window_p    (4),
        .drain_p     (2),
        .cnt_width_p (8)
    ) dut (
        .clk_i          (clk_i),
        .reset_n_i      (reset_n_i),
        .enable_i       (enable_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .mac_valid_o    (mac_valid_o),
        .mac_ready_i    (mac_ready_i),
        .mac_clear_o    (mac_clear_o),
        .mac_data_i     (mac_data_i),
        .result_o       (result_o),
        .result_mag_o   (result_mag_o),
        .result_v_o     (result_v_o),
        .window_count_o (window_count_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_result(input logic [31:0] res, input logic [31:0] mag);
        exp_t e;
        exp_cnt = exp_cnt + 8'd1;
        e.res = res;
        e.mag = mag;
        e.cnt = exp_cnt;
        sb.push_back(e);
    endtask

    // Monitor: every result_v_o pulse must match the oldest queued expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (result_v_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_result_v", 32'(result_v_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("result_o", result_o, e.res);
                check("result_mag_o", result_mag_o, e.mag);
                check("window_count_o", 32'(window_count_o), 32'(e.cnt));
            end
        end
    end

    // Starts and ends at a negedge; drives valid=1 and counts handshakes.
    task automatic accumulate(input int n_hs, input int stall_after, input int drop_after);
        int   hs = 0;
        int   stall_left = 0;
        int   guard = 0;
        logic hs_now;
        while (hs < n_hs && guard < 40) begin
            hs_now = sample_valid_i && sample_ready_o;
            @(posedge clk_i); #1;
            guard++;
            if (hs_now) begin
                hs++;
                if (hs == stall_after) stall_left = 3;
                if (hs == drop_after) enable_i = 1'b0;
            end
            mac_ready_i = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            @(negedge clk_i);
            if (!mac_ready_i) begin
                check("stall_sample_ready", 32'(sample_ready_o), 32'd0);
                check("stall_mac_valid", 32'(mac_valid_o), 32'd1);
            end
            if (hs_now && hs == 3) check("open_after_3", 32'(sample_ready_o), 32'd1);
            if (hs_now && hs == 4) check("closed_after_4", 32'(sample_ready_o), 32'd0);
        end
        if (hs < n_hs) check("accum_timeout", hs, n_hs);
    endtask

    task automatic measure_gap(output int gap);
        gap = 0;
        while (!sample_ready_o && gap < 20) begin
            gap++;
            @(negedge clk_i);
        end
    endtask

    task automatic wait_accum();
        int g = 0;
        while (!sample_ready_o && g < 10) begin
            g++;
            @(negedge clk_i);
        end
        check("accum_entry", 32'(sample_ready_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int gap;
        reset_n_i      = 1'b0;
        enable_i       = 1'b0;
        sample_valid_i = 1'b0;
        mac_ready_i    = 1'b1;
        mac_data_i     = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_result_o", result_o, 32'd0);
        check("rst_result_mag_o", result_mag_o, 32'd0);
        check("rst_result_v_o", 32'(result_v_o), 32'd0);
        check("rst_window_count_o", 32'(window_count_o), 32'd0);
        check("rst_busy_o", 32'(busy_o), 32'd0);
        check("rst_mac_clear_o", 32'(mac_clear_o), 32'd0);
        check("rst_sample_ready_o", 32'(sample_ready_o), 32'd0);

        // Window 1: release reset with enable high, plain positive result.
        @(posedge clk_i); #1;
        reset_n_i      = 1'b1;
        enable_i       = 1'b1;
        sample_valid_i = 1'b1;
        mac_data_i     = 32'h0000_0123;
        expect_result(32'h0000_0123, 32'h0000_0123);
        @(negedge clk_i);
        check("idle_mac_clear", 32'(mac_clear_o), 32'd0);
        check("idle_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        check("clear_pulse", 32'(mac_clear_o), 32'd1);
        check("clear_sample_ready", 32'(sample_ready_o), 32'd0);
        check("clear_busy", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        check("clear_one_cycle", 32'(mac_clear_o), 32'd0);
        check("accum_sample_ready", 32'(sample_ready_o), 32'd1);
        accumulate(4, 0, 0);
        measure_gap(gap);
        check("gap_w1", gap, 4);

        // Window 2: negative result, 3-cycle MAC stall after the 2nd handshake.
        mac_data_i = 32'hFFFF_FF00;
        expect_result(32'hFFFF_FF00, 32'h0000_0100);
        accumulate(4, 2, 0);
        measure_gap(gap);
        check("gap_w2", gap, 4);

        // Window 3: most-negative saturation, enable dropped after 2nd handshake.
        mac_data_i = 32'h8000_0000;
        expect_result(32'h8000_0000, 32'h7FFF_FFFF);
        accumulate(4, 0, 2);
        repeat (6) @(negedge clk_i);
        check("idle_after_drop_busy", 32'(busy_o), 32'd0);
        check("idle_after_drop_ready", 32'(sample_ready_o), 32'd0);
        check("result_hold", result_o, 32'h8000_0000);
        check("count_after_3", 32'(window_count_o), 32'd3);

        // Reset after the 3rd handshake discards the window.
        @(posedge clk_i); #1;
        enable_i   = 1'b1;
        mac_data_i = 32'h0000_0055;
        wait_accum();
        accumulate(3, 0, 0);
        @(posedge clk_i); #1;
        reset_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("midrst_result_o", result_o, 32'd0);
        check("midrst_result_mag_o", result_mag_o, 32'd0);
        check("midrst_window_count", 32'(window_count_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        exp_cnt = 8'd0;

        // 256 back-to-back windows: the window counter wraps to 0.
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        wait_accum();
        for (int i = 1; i <= 256; i++) begin
            mac_data_i = 32'(i);
            expect_result(32'(i), 32'(i));
            if (i < 256) begin
                accumulate(4, 0, 0);
                measure_gap(gap);
                check("gap_wrap", gap, 4);
            end else begin
                accumulate(4, 0, 1);
            end
        end
        repeat (8) @(negedge clk_i);
        check("wrap_window_count", 32'(window_count_o), 32'd0);
        check("wrap_idle_busy", 32'(busy_o), 32'd0);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
